// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Definitions shared by the UART command framer and the command dispatcher:
//   state_t   - framer FSM states
//   FRAME_LEN - bytes per command frame (3, or 4 when CMD_CHKSUM_EN is defined)
//   OP_*      - opcode values understood by the dispatcher
//   frame_xor - XOR of all frame bytes; a good checksummed frame yields 8'h00
// Optional feature macro: CMD_CHKSUM_EN (adds a trailing checksum byte).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DAT_HI = 3'd1,
    DAT_LO = 3'd2,
    CHK    = 3'd3,
    HOLD   = 3'd4
  } state_t;

`ifdef CMD_CHKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h06;
  localparam logic [7:0] OP_RESET = 8'h0F;

  function automatic logic [7:0] frame_xor(input logic [7:0] op,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo,
                                           input logic [7:0] chk);
    return op ^ hi ^ lo ^ chk;
  endfunction

endpackage

// File: rtl/uart_cmd_framer_if.sv
// uart_cmd_framer_if
// Bundles the receiver-side byte handshake and the dispatcher-side command
// handshake of the UART command framer.
//   rx_rdy, rx_data   : byte-ready level and byte from the UART receiver
//   clr_rx_rdy        : one-cycle pulse clearing the receiver's rdy flag
//   cmd_vld, opcode,
//   data, cmd_ack     : command valid/ack handshake towards the dispatcher
//   frm_err           : one-cycle pulse on timeout or checksum failure
// Modports: slave = the framer, master = the environment driving it.
interface uart_cmd_framer_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_vld;
  logic [7:0]  opcode;
  logic [15:0] data;
  logic        cmd_ack;
  logic        frm_err;

  modport slave (
    input  rx_rdy, rx_data, cmd_ack,
    output clr_rx_rdy, cmd_vld, opcode, data, frm_err
  );

  modport master (
    output rx_rdy, rx_data, cmd_ack,
    input  clr_rx_rdy, cmd_vld, opcode, data, frm_err
  );
endinterface

// File: rtl/frame_timer.sv
// frame_timer
// Inter-byte idle counter used by the framer to drop stale partial frames.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : force the count to zero (has priority over run)
//   run      : count one cycle
//   expire   : count has reached TIMEOUT_CYC-1 while running
// Parameter TIMEOUT_CYC (>= 2) sets the expiry point.
module frame_timer #(
  parameter int TIMEOUT_CYC = 52080
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  assign expire = run & (count == LAST);

  // Stops at LAST; the framer leaves the counting states on expiry anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run & ~expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
// Assembles UART bytes into command frames (opcode, data[15:8], data[7:0]
// and, with CMD_CHKSUM_EN defined, a checksum byte) and holds each complete
// command on a valid/ack handshake. Every captured byte is acknowledged to
// the receiver with a one-cycle clr_rx_rdy pulse. A partial frame that sits
// idle for TIMEOUT_CYC cycles is dropped with a frm_err pulse.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : uart_cmd_framer_if.slave (receiver + dispatcher handshakes)
// Parameter TIMEOUT_CYC (>= 2): idle cycles allowed between bytes of a frame.
// Optional feature macro: CMD_CHKSUM_EN.
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 52080
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_framer_if.slave    bus
);

  state_t      state;
  state_t      state_nxt;
  logic        take;
  logic        counting;
  logic        expire;
  logic        err_nxt;
  logic        ld_op;
  logic        ld_hi;
  logic        ld_lo;
  logic [7:0]  opcode_q;
  logic [15:0] data_q;
  logic        clr_q;
  logic        err_q;

  // The ~clr_q term stops a second capture of the same byte in the cycle
  // where the receiver's rdy has not yet dropped.
  assign take = bus.rx_rdy & ~clr_q & (state != HOLD);

`ifdef CMD_CHKSUM_EN
  assign counting = (state == DAT_HI) | (state == DAT_LO) | (state == CHK);
`else
  assign counting = (state == DAT_HI) | (state == DAT_LO);
`endif

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (take | ~counting),
    .run    (counting),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A take in the expiry cycle wins, so expire is only looked at without one.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    ld_op     = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          ld_op     = 1'b1;
          state_nxt = DAT_HI;
        end
      end
      DAT_HI: begin
        if (take) begin
          ld_hi     = 1'b1;
          state_nxt = DAT_LO;
        end else if (expire) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DAT_LO: begin
        if (take) begin
          ld_lo     = 1'b1;
`ifdef CMD_CHKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = HOLD;
`endif
        end else if (expire) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef CMD_CHKSUM_EN
      CHK: begin
        if (take) begin
          if (frame_xor(opcode_q, data_q[15:8], data_q[7:0], bus.rx_data) == 8'h00) begin
            state_nxt = HOLD;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (expire) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      HOLD: begin
        if (bus.cmd_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= 8'h00;
      data_q   <= 16'h0000;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clr_q <= take;
      err_q <= err_nxt;
      if (ld_op) opcode_q      <= bus.rx_data;
      if (ld_hi) data_q[15:8]  <= bus.rx_data;
      if (ld_lo) data_q[7:0]   <= bus.rx_data;
    end
  end

  assign bus.clr_rx_rdy = clr_q;
  assign bus.frm_err    = err_q;
  assign bus.cmd_vld    = (state == HOLD);
  assign bus.opcode     = opcode_q;
  assign bus.data       = data_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer
// Self-checking bench for uart_cmd_framer. A reference model turns the byte
// stream and its take times into expected events (command or frm_err, with
// the cycle they must appear in) pushed onto a scoreboard queue; a monitor
// pops and compares them whenever the DUT raises cmd_vld or frm_err.
// Honours CMD_CHKSUM_EN through uart_cmd_pkg::FRAME_LEN.
module tb_uart_cmd_framer;
  import uart_cmd_pkg::*;

  localparam int TO = 100;

  typedef struct {
    bit          is_err;
    logic [7:0]  op;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  uart_cmd_framer_if bus();

  uart_cmd_framer #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_take = 0;
  int         clr_cycles = 0;
  int         bytes_sent = 0;
  int         ack_cyc = 0;
  bit         ack_en = 1'b1;
  bit         hold_expected = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a byte taken more than TO cycles after the previous
  // byte of an unfinished frame means that frame timed out TO+1 cycles after
  // its last take; a full frame yields a command (or an error on bad XOR)
  // in the cycle after its last take.
  task automatic model_byte(input logic [7:0] b, input int take_cyc);
    exp_t e;
    logic [7:0] x;
    if (frame_q.size() > 0 && (take_cyc - last_take) > TO) begin
      e.is_err = 1'b1; e.op = 8'h00; e.dat = 16'h0000; e.cyc = last_take + TO + 1;
      exp_q.push_back(e);
      frame_q.delete();
    end
    frame_q.push_back(b);
    last_take = take_cyc;
    if (frame_q.size() == FRAME_LEN) begin
      e.op  = frame_q[0];
      e.dat = {frame_q[1], frame_q[2]};
      e.cyc = take_cyc + 1;
      e.is_err = 1'b0;
`ifdef CMD_CHKSUM_EN
      x = 8'h00;
      foreach (frame_q[i]) x = x ^ frame_q[i];
      e.is_err = (x != 8'h00);
`endif
      exp_q.push_back(e);
      hold_expected = !e.is_err;
      frame_q.delete();
    end
  endtask

  // Receiver model: rdy is raised gap-1 negedges after entry and dropped
  // once clr_rx_rdy is seen.
  task automatic drive_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap - 1) @(negedge clk);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.clr_rx_rdy && w < 500);
    if (!bus.clr_rx_rdy) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL rx_rdy_cleared: clr_rx_rdy=0 after %0d cycles, required 1", w);
    end
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'($urandom);
    bytes_sent++;
  endtask

  task automatic wait_release();
    int w;
    w = 0;
    while (bus.cmd_vld && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (bus.cmd_vld) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL cmd_released: cmd_vld=1 after %0d cycles, required 0", w);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    model_byte(b, cyc + gap - 1);
    drive_byte(b, gap);
    if (hold_expected) begin
      hold_expected = 1'b0;
      if (ack_en) wait_release();
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] d, input int g0, input int g);
    applyStimulus(op, g0);
    applyStimulus(d[15:8], g);
    applyStimulus(d[7:0], g);
`ifdef CMD_CHKSUM_EN
    applyStimulus(op ^ d[15:8] ^ d[7:0], g);
`endif
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return TO + 1 + $urandom_range(0, 4);
      1:       return TO;
      2:       return TO - 1;
      default: return $urandom_range(2, 8);
    endcase
  endfunction

  // Dispatcher model: acks after a random delay, and toggles a spurious ack
  // while no command is held.
  initial begin : acker
    int wait_cnt;
    wait_cnt = 0;
    bus.cmd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cmd_vld && ack_en) begin
        if (wait_cnt == 0) begin
          bus.cmd_ack = 1'b1;
          ack_cyc     = cyc;
          wait_cnt    = $urandom_range(0, 4);
        end else begin
          bus.cmd_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        bus.cmd_ack = !bus.cmd_vld && ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : monitor
    exp_t        cur;
    bit          prev_vld;
    bit          in_hold;
    logic [7:0]  hold_op;
    logic [15:0] hold_dat;
    prev_vld = 1'b0; in_hold = 1'b0; hold_op = 8'h00; hold_dat = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 1'b0;
        in_hold  = 1'b0;
      end else begin
        if (bus.clr_rx_rdy) clr_cycles++;
        if (bus.frm_err) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL unexpected_frm_err: frm_err=1 at cycle %0d, required no event", cyc);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("event_kind_err", bus.frm_err, cur.is_err);
            checkOutput("err_cycle", cyc, cur.cyc);
          end
        end
        if (bus.cmd_vld && !prev_vld) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL unexpected_cmd: cmd_vld=1 opcode=%0h data=%0h at cycle %0d, required no event",
                     bus.opcode, bus.data, cyc);
            in_hold = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            checkOutput("event_kind_cmd", bus.frm_err, cur.is_err);
            checkOutput("cmd_cycle", cyc, cur.cyc);
            checkOutput("opcode", bus.opcode, cur.op);
            checkOutput("data", bus.data, cur.dat);
            hold_op  = cur.op;
            hold_dat = cur.dat;
            in_hold  = 1'b1;
          end
        end else if (bus.cmd_vld && in_hold) begin
          checkOutput("opcode_stable", bus.opcode, hold_op);
          checkOutput("data_stable", bus.data, hold_dat);
        end
        if (!bus.cmd_vld) in_hold = 1'b0;
        prev_vld = bus.cmd_vld;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: still running at time %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int c0;
    int clr_seen;
    int w;
    rst = 1'b1;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_vld", bus.cmd_vld, 0);
    checkOutput("reset_clr_rx_rdy", bus.clr_rx_rdy, 0);
    checkOutput("reset_frm_err", bus.frm_err, 0);
    checkOutput("reset_opcode", bus.opcode, 0);
    checkOutput("reset_data", bus.data, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic frame 05 12 34");
    c0 = clr_cycles;
    send_frame(8'h05, 16'h1234, 3, 3);
    #1;
    checkOutput("clr_cycles_per_frame", clr_cycles - c0, FRAME_LEN);

    $display("[TB] backpressure with pending byte");
    ack_en = 1'b0;
    send_frame(8'h05, 16'h1234, 3, 2);
    @(negedge clk);
    bus.rx_data = 8'hA7;
    bus.rx_rdy  = 1'b1;
    clr_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.clr_rx_rdy) clr_seen++;
    end
    checkOutput("hold_no_clr", clr_seen, 0);
    checkOutput("hold_cmd_vld", bus.cmd_vld, 1);
    ack_en = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.clr_rx_rdy && w < 100);
    checkOutput("take_after_ack", cyc - 1, ack_cyc + 1);
    model_byte(8'hA7, ack_cyc + 1);
    bus.rx_rdy = 1'b0;
    bytes_sent++;
    applyStimulus(8'h56, 2);
    applyStimulus(8'h78, 2);
`ifdef CMD_CHKSUM_EN
    applyStimulus(8'hA7 ^ 8'h56 ^ 8'h78, 2);
`endif

    $display("[TB] timeout then clean frame");
    applyStimulus(8'h05, 3);
    applyStimulus(8'h12, 3);
    send_frame(8'h9A, 16'hBCDE, TO + 8, 3);

    $display("[TB] byte in the expiry cycle");
    send_frame(8'h11, 16'h2233, 3, TO);

    $display("[TB] reset in DAT_LO");
    applyStimulus(8'h05, 3);
    applyStimulus(8'h12, 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_cmd_vld", bus.cmd_vld, 0);
    checkOutput("midrst_clr_rx_rdy", bus.clr_rx_rdy, 0);
    checkOutput("midrst_frm_err", bus.frm_err, 0);
    checkOutput("midrst_opcode", bus.opcode, 0);
    checkOutput("midrst_data", bus.data, 0);
    frame_q.delete();
    hold_expected = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h42, 16'h0F0F, 3, 3);

`ifdef CMD_CHKSUM_EN
    $display("[TB] checksum good and bad");
    applyStimulus(8'h05, 3);
    applyStimulus(8'h12, 3);
    applyStimulus(8'h34, 3);
    applyStimulus(8'h23, 3);
    applyStimulus(8'h05, 3);
    applyStimulus(8'h12, 3);
    applyStimulus(8'h34, 3);
    applyStimulus(8'h24, 3);
`endif

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      logic [7:0]  op;
      logic [15:0] d;
      op = 8'($urandom);
      d  = 16'($urandom);
      applyStimulus(op, pick_gap());
      applyStimulus(d[15:8], pick_gap());
      applyStimulus(d[7:0], pick_gap());
`ifdef CMD_CHKSUM_EN
      if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom), pick_gap());
      else applyStimulus(op ^ d[15:8] ^ d[7:0], pick_gap());
`endif
    end

    if (frame_q.size() > 0) begin
      exp_t e;
      e.is_err = 1'b1; e.op = 8'h00; e.dat = 16'h0000; e.cyc = last_take + TO + 1;
      exp_q.push_back(e);
      frame_q.delete();
    end
    repeat (TO + 10) @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("clr_cycles_total", clr_cycles, bytes_sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
